// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding, parity modes and bit-period default for the serial transmitter/receiver pair
package serial_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} serial_state_t;
  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD = 1'b1;
  localparam int DEFAULT_CLKS_PER_BIT = 16;
endpackage

// File: rtl/rx_sync.sv
// rx_sync: 2-flop synchroniser plus falling-edge detect; ports clk, rst (async high), rx in, rx_s synced line, fall = 1->0 on rx_s
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  logic meta, prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) {meta, rx_s, prev} <= 3'b111;
    else {meta, rx_s, prev} <= {rx, meta, rx_s};
  assign fall = prev & ~rx_s;
endmodule

// File: rtl/serial_receiver.sv
// serial_receiver: deserialises idle-high start/LSB-first/parity/stop frames; ports wb_clk, wb_rst (async high), rx line, ack in; data_out, valid, frame_err, parity_err, overrun (sticky), busy out
module serial_receiver
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit PARITY_EN = 1'b1,
  parameter bit PARITY_ODD = PAR_EVEN
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  rx,
  input  logic                  ack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun,
  output logic                  busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
  serial_state_t state;
  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic par_bad, rx_s, fall, tick;
  rx_sync u_sync (.clk(wb_clk), .rst(wb_rst), .rx(rx), .rx_s(rx_s), .fall(fall));
  // START waits half a bit to land mid start bit; every later sample is a full bit on
  assign tick = clk_cnt == (state == START ? HALF : FULL);
  always_ff @(posedge wb_clk or posedge wb_rst)
    if (wb_rst) begin
      state <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift_reg <= '0;
      par_bad <= 1'b0;
      data_out <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun <= 1'b0;
      busy <= 1'b0;
    end else begin
      // a completion later in this block overrides these clears
      if (ack && valid) begin
        valid <= 1'b0;
        overrun <= 1'b0;
      end
      clk_cnt <= (tick || state == IDLE || state == WAIT_IDLE) ? '0 : clk_cnt + CW'(1);
      case (state)
        IDLE: if (fall) begin
          state <= START;
          busy <= 1'b1;
        end
        START: if (tick) begin
          bit_cnt <= '0;
          state <= rx_s ? IDLE : DATA;
          busy <= ~rx_s;
        end
        DATA: if (tick) begin
          shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_cnt == LAST) state <= PARITY_EN ? PARITY : STOP;
        end
        PARITY: if (tick) begin
          par_bad <= (^shift_reg ^ rx_s) != PARITY_ODD;
          state <= STOP;
        end
        STOP: if (tick) begin
          if (!valid || ack) begin
            data_out <= shift_reg;
            frame_err <= ~rx_s;
            parity_err <= PARITY_EN && par_bad;
            valid <= 1'b1;
          end else overrun <= 1'b1;
          // a low stop bit may be a break; hold off until the line returns high
          state <= rx_s ? IDLE : WAIT_IDLE;
          busy <= ~rx_s;
        end
        WAIT_IDLE: if (rx_s) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed + random frames into even- and odd-parity receivers sharing one line, scoreboard-checked
module tb_serial_receiver;
  import serial_pkg::*;
  localparam int CPB = 16;
  typedef struct {
    logic [7:0] d;
    logic fe;
    logic pe_e;
    logic pe_o;
  } exp_t;
  exp_t q[$];
  logic clk, rst, rx, ack;
  logic [7:0] d_e, d_o;
  logic v_e, fe_e, pe_e, ov_e, b_e;
  logic v_o, fe_o, pe_o, ov_o, b_o;
  int errors = 0, checks = 0;
  serial_receiver dut_e (
    .wb_clk(clk), .wb_rst(rst), .rx(rx), .ack(ack), .data_out(d_e), .valid(v_e),
    .frame_err(fe_e), .parity_err(pe_e), .overrun(ov_e), .busy(b_e)
  );
  serial_receiver #(.PARITY_ODD(PAR_ODD)) dut_o (
    .wb_clk(clk), .wb_rst(rst), .rx(rx), .ack(ack), .data_out(d_o), .valid(v_o),
    .frame_err(fe_o), .parity_err(pe_o), .overrun(ov_o), .busy(b_o)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [7:0] d, input logic p, input logic stp);
    q.push_back('{d, ~stp, (^d ^ p) != 1'b0, (^d ^ p) != 1'b1});
  endtask
  // called at a negedge; drives one frame, optionally holding a low stop bit or cutting the frame short
  task automatic send(input logic [7:0] d, input logic p, input logic stp, input int hold, input int cut);
    logic [10:0] bits;
    int c;
    bits = {stp, p, d, 1'b0};
    c = 0;
    for (int b = 0; b < 11; b++)
      for (int k = 0; k < CPB; k++) begin
        if (cut > 0 && c == cut) begin
          rx = 1'b1;
          return;
        end
        rx = bits[b];
        c++;
        @(negedge clk);
      end
    if (!stp) repeat (hold) @(negedge clk);
    rx = 1'b1;
  endtask
  task automatic expect_frame(input string tag);
    exp_t e;
    int t;
    t = 0;
    while (!v_e && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "-valid"}, {31'b0, v_e}, 1);
    chk({tag, "-valid_o"}, {31'b0, v_o}, 1);
    if (q.size() == 0) chk({tag, "-scoreboard_empty"}, 0, 1);
    else begin
      e = q.pop_front();
      chk({tag, "-data"}, {24'b0, d_e}, {24'b0, e.d});
      chk({tag, "-data_o"}, {24'b0, d_o}, {24'b0, e.d});
      chk({tag, "-frame_err"}, {31'b0, fe_e}, {31'b0, e.fe});
      chk({tag, "-parity_err"}, {31'b0, pe_e}, {31'b0, e.pe_e});
      chk({tag, "-parity_err_o"}, {31'b0, pe_o}, {31'b0, e.pe_o});
    end
  endtask
  task automatic ack_pulse(input string tag);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk({tag, "-ack_clears_valid"}, {31'b0, v_e}, 0);
    chk({tag, "-ack_clears_overrun"}, {31'b0, ov_e}, 0);
  endtask
  initial begin
    int lat;
    logic [7:0] r;
    rst = 1'b1;
    rx = 1'b1;
    ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst-data", {24'b0, d_e}, 0);
    chk("rst-flags", {27'b0, v_e, fe_e, pe_e, ov_e, b_e}, 0);
    rst = 1'b0;
    @(negedge clk);
    // good frame, latency measured from the pin edge
    push(8'hA5, 1'b0, 1'b1);
    lat = 0;
    fork
      send(8'hA5, 1'b0, 1'b1, 0, 0);
      while (!v_e && lat < 400) begin
        @(negedge clk);
        lat++;
      end
    join
    chk("a5-latency", {31'b0, lat >= 170 && lat <= 172}, 1);
    expect_frame("a5");
    ack_pulse("a5");
    // start-bit glitch
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    chk("glitch-busy_hi", {31'b0, b_e}, 1);
    repeat (8) @(negedge clk);
    chk("glitch-busy_lo", {31'b0, b_e}, 0);
    chk("glitch-valid", {31'b0, v_e}, 0);
    // parity bit 1 on 0x3C: wrong for even, right for odd
    push(8'h3C, 1'b1, 1'b1);
    send(8'h3C, 1'b1, 1'b1, 0, 0);
    expect_frame("3c");
    ack_pulse("3c");
    // low stop bit then break held low
    push(8'h81, 1'b0, 1'b0);
    fork
      send(8'h81, 1'b0, 1'b0, 40, 0);
      begin
        repeat (200) @(negedge clk);
        chk("break-busy_wait_idle", {31'b0, b_e}, 1);
      end
    join
    expect_frame("81");
    repeat (4) @(negedge clk);
    chk("break-busy_released", {31'b0, b_e}, 0);
    ack_pulse("81");
    push(8'h55, 1'b0, 1'b1);
    send(8'h55, 1'b0, 1'b1, 0, 0);
    expect_frame("55");
    ack_pulse("55");
    // overrun: second frame dropped
    push(8'h11, 1'b0, 1'b1);
    send(8'h11, 1'b0, 1'b1, 0, 0);
    send(8'h22, 1'b0, 1'b1, 0, 0);
    repeat (2) @(negedge clk);
    chk("ovr-overrun", {31'b0, ov_e}, 1);
    chk("ovr-overrun_o", {31'b0, ov_o}, 1);
    expect_frame("ovr");
    ack_pulse("ovr");
    // ack on the completion edge of 0x22 delivers it without overrun
    push(8'h11, 1'b0, 1'b1);
    send(8'h11, 1'b0, 1'b1, 0, 0);
    expect_frame("pre22");
    push(8'h22, 1'b0, 1'b1);
    fork
      send(8'h22, 1'b0, 1'b1, 0, 0);
      begin
        repeat (170) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    expect_frame("22");
    chk("22-overrun", {31'b0, ov_e}, 0);
    // reset mid-frame while valid is still set
    send(8'hF0, 1'b0, 1'b1, 0, 60);
    chk("f0-busy_before_rst", {31'b0, b_e}, 1);
    rst = 1'b1;
    #1;
    chk("f0-rst_data", {24'b0, d_e}, 0);
    chk("f0-rst_flags", {27'b0, v_e, fe_e, pe_e, ov_e, b_e}, 0);
    chk("f0-rst_flags_o", {27'b0, v_o, fe_o, pe_o, ov_o, b_o}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(8'h0F, 1'b0, 1'b1);
    send(8'h0F, 1'b0, 1'b1, 0, 0);
    expect_frame("0f");
    ack_pulse("0f");
    // random loopback with correct even parity
    for (int i = 0; i < 256; i++) begin
      r = 8'($urandom_range(0, 255));
      push(r, ^r, 1'b1);
      send(r, ^r, 1'b1, 0, 0);
      expect_frame("rand");
      ack_pulse("rand");
    end
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
